// File: rtl/pipelined_comparator_if.sv
// Handshake and data bundle for pipelined_comparator.
// The slave modport is the comparator's view and the master modport is the traffic source/sink's view.
interface pipelined_comparator_if #(
   parameter int WORD_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
);
   logic                  valid_i;
   logic                  ready_o;
   logic [WORD_WIDTH-1:0] a_i;
   logic [WORD_WIDTH-1:0] b_i;
   logic                  signed_i;
   logic [TAG_WIDTH-1:0]  tag_i;
   logic                  valid_o;
   logic                  ready_i;
   logic                  above_o;
   logic                  below_o;
   logic                  equal_o;
   logic [WORD_WIDTH-1:0] max_o;
   logic [WORD_WIDTH-1:0] min_o;
   logic [TAG_WIDTH-1:0]  tag_o;

   modport slave (
      input  valid_i, a_i, b_i, signed_i, tag_i, ready_i,
      output ready_o, valid_o, above_o, below_o, equal_o, max_o, min_o, tag_o
   );

   modport master (
      output valid_i, a_i, b_i, signed_i, tag_i, ready_i,
      input  ready_o, valid_o, above_o, below_o, equal_o, max_o, min_o, tag_o
   );
endinterface

// File: rtl/pipelined_comparator.sv
// Pipelined, handshaked signed/unsigned magnitude comparator built as a binary gt/lt tree.
// Optional saturating per-result handshake counters are enabled by defining PIPELINED_COMPARATOR_STATS_EN.
module pipelined_comparator #(
   parameter int WORD_WIDTH  = 32,
   parameter int PIPE_STAGES = 1,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
`ifdef PIPELINED_COMPARATOR_STATS_EN
   input  logic                  stat_clr_i,
   output logic [31:0]           stat_above_o,
   output logic [31:0]           stat_below_o,
   output logic [31:0]           stat_equal_o,
`endif
   pipelined_comparator_if.slave bus
);
   localparam int LEVELS = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 0;
   localparam int LEAVES = 1 << LEVELS;

   logic                  r_valid_o;
   logic                  r_above;
   logic                  r_below;
   logic                  r_equal;
   logic [WORD_WIDTH-1:0] r_max;
   logic [WORD_WIDTH-1:0] r_min;
   logic [TAG_WIDTH-1:0]  r_tag;

   logic                  w_stall;
   logic                  w_accept;
   logic [WORD_WIDTH-1:0] w_sign_mask;
   logic [WORD_WIDTH-1:0] w_a_x;
   logic [WORD_WIDTH-1:0] w_b_x;

   // The stall is built only from the registered valid_o and ready_i, so ready_o never waits on valid_i.
   assign w_stall     = r_valid_o & ~bus.ready_i;
   assign bus.ready_o = ~w_stall;
   assign w_accept    = bus.valid_i & ~w_stall;

   // Flipping both MSBs maps two's-complement order onto unsigned order.
   assign w_sign_mask = WORD_WIDTH'(bus.signed_i) << (WORD_WIDTH - 1);
   assign w_a_x       = bus.a_i ^ w_sign_mask;
   assign w_b_x       = bus.b_i ^ w_sign_mask;

   for (genvar k = 0; k <= LEVELS; k++) begin : g_level
      localparam int CNT = LEAVES >> k;

      logic [CNT-1:0]        w_ogt;
      logic [CNT-1:0]        w_olt;
      logic [WORD_WIDTH-1:0] w_oa;
      logic [WORD_WIDTH-1:0] w_ob;
      logic [TAG_WIDTH-1:0]  w_otag;
      logic                  w_ovalid;

      if (k == 0) begin : g_leaf
         // Operand bits sit at the MSB end; padding leaves below them are zero (neither gt nor lt).
         assign w_ogt    = CNT'(w_a_x & ~w_b_x) << (CNT - WORD_WIDTH);
         assign w_olt    = CNT'(~w_a_x & w_b_x) << (CNT - WORD_WIDTH);
         assign w_oa     = bus.a_i;
         assign w_ob     = bus.b_i;
         assign w_otag   = bus.tag_i;
         assign w_ovalid = w_accept;
      end else begin : g_merge
         // A register sits after level k whenever the running share of cuts steps up here,
         // which pushes the extra cut of an uneven split towards the output.
         localparam bit CUT = ((k * PIPE_STAGES) / LEVELS) > (((k - 1) * PIPE_STAGES) / LEVELS);

         logic [CNT-1:0] w_mgt;
         logic [CNT-1:0] w_mlt;

         for (genvar j = 0; j < CNT; j++) begin : g_node
            assign w_mgt[j] = g_level[k-1].w_ogt[2*j+1]
                            | (g_level[k-1].w_ogt[2*j] & ~g_level[k-1].w_olt[2*j+1]);
            assign w_mlt[j] = g_level[k-1].w_olt[2*j+1]
                            | (g_level[k-1].w_olt[2*j] & ~g_level[k-1].w_ogt[2*j+1]);
         end

         if (CUT) begin : g_cut
            logic [CNT-1:0]        r_stage_gt;
            logic [CNT-1:0]        r_stage_lt;
            logic [WORD_WIDTH-1:0] r_stage_a;
            logic [WORD_WIDTH-1:0] r_stage_b;
            logic [TAG_WIDTH-1:0]  r_stage_tag;
            logic                  r_stage_valid;

            // NOTE: state registers use non-blocking (<=) so every stage samples the pre-edge values of the stage before it.
            always_ff @(posedge clk_i or negedge rst_ni) begin
               if (!rst_ni) begin
                  r_stage_valid <= 1'b0;
                  r_stage_gt    <= '0;
                  r_stage_lt    <= '0;
                  r_stage_a     <= '0;
                  r_stage_b     <= '0;
                  r_stage_tag   <= '0;
               end else if (!w_stall) begin
                  r_stage_valid <= g_level[k-1].w_ovalid;
                  r_stage_gt    <= w_mgt;
                  r_stage_lt    <= w_mlt;
                  r_stage_a     <= g_level[k-1].w_oa;
                  r_stage_b     <= g_level[k-1].w_ob;
                  r_stage_tag   <= g_level[k-1].w_otag;
               end
            end

            assign w_ogt    = r_stage_gt;
            assign w_olt    = r_stage_lt;
            assign w_oa     = r_stage_a;
            assign w_ob     = r_stage_b;
            assign w_otag   = r_stage_tag;
            assign w_ovalid = r_stage_valid;
         end else begin : g_pass
            assign w_ogt    = w_mgt;
            assign w_olt    = w_mlt;
            assign w_oa     = g_level[k-1].w_oa;
            assign w_ob     = g_level[k-1].w_ob;
            assign w_otag   = g_level[k-1].w_otag;
            assign w_ovalid = g_level[k-1].w_ovalid;
         end
      end
   end

   // The output register always exists; bubbles also load here so valid_o drops once a result is taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid_o <= 1'b0;
         r_above   <= 1'b0;
         r_below   <= 1'b0;
         r_equal   <= 1'b0;
         r_max     <= '0;
         r_min     <= '0;
         r_tag     <= '0;
      end else if (!w_stall) begin
         r_valid_o <= g_level[LEVELS].w_ovalid;
         r_above   <= g_level[LEVELS].w_ogt[0];
         r_below   <= g_level[LEVELS].w_olt[0];
         r_equal   <= ~(g_level[LEVELS].w_ogt[0] | g_level[LEVELS].w_olt[0]);
         r_max     <= g_level[LEVELS].w_olt[0] ? g_level[LEVELS].w_ob : g_level[LEVELS].w_oa;
         r_min     <= g_level[LEVELS].w_olt[0] ? g_level[LEVELS].w_oa : g_level[LEVELS].w_ob;
         r_tag     <= g_level[LEVELS].w_otag;
      end
   end

   assign bus.valid_o = r_valid_o;
   assign bus.above_o = r_above;
   assign bus.below_o = r_below;
   assign bus.equal_o = r_equal;
   assign bus.max_o   = r_max;
   assign bus.min_o   = r_min;
   assign bus.tag_o   = r_tag;

`ifdef PIPELINED_COMPARATOR_STATS_EN
   logic [31:0] r_stat_above;
   logic [31:0] r_stat_below;
   logic [31:0] r_stat_equal;
   logic        w_out_hs;

   assign w_out_hs = r_valid_o & bus.ready_i;

   // Clear wins over a same-cycle increment; each counter sticks at all-ones.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stat_above <= '0;
         r_stat_below <= '0;
         r_stat_equal <= '0;
      end else if (stat_clr_i) begin
         r_stat_above <= '0;
         r_stat_below <= '0;
         r_stat_equal <= '0;
      end else if (w_out_hs) begin
         if (r_above && (r_stat_above != '1)) r_stat_above <= r_stat_above + 32'd1;
         if (r_below && (r_stat_below != '1)) r_stat_below <= r_stat_below + 32'd1;
         if (r_equal && (r_stat_equal != '1)) r_stat_equal <= r_stat_equal + 32'd1;
      end
   end

   assign stat_above_o = r_stat_above;
   assign stat_below_o = r_stat_below;
   assign stat_equal_o = r_stat_equal;
`endif
endmodule
